// File: rtl/chain_latency_meter.sv
// Launch/capture latency meter for the delay-chain test array.
// Optional CLM_AVG4_EN: four alternating-edge passes averaged into result.
module chain_latency_meter #(
  parameter int          CNT_W       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 32'h0000_FFFE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       lane_sel,
  input  logic [7:0]       chain_in,
  output logic             launch_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] result
);

  localparam logic [CNT_W-1:0] L_TMO = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_COUNT,
    S_FINISH
  } state_t;

  state_t                            r_state;
  logic [SYNC_STAGES-1:0][7:0]       r_sync;
  logic [2:0]                        r_lane;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_launch;
  logic                              r_busy;
  logic                              r_done;
  logic                              r_timeout;
  logic [CNT_W-1:0]                  r_result;

  logic                              w_lane;
  logic                              w_match;
  logic                              w_tmo;
  logic [CNT_W-1:0]                  w_cnt_inc;

`ifdef CLM_AVG4_EN
  logic [1:0]                        r_pass;
  logic [CNT_W+1:0]                  r_acc;
  logic [CNT_W+1:0]                  w_sum;

  assign w_sum = r_acc + {2'b00, r_cnt};
`endif

  // Plain flop chain; chain_in is fully asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= chain_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_lane    = r_sync[SYNC_STAGES-1][r_lane];
  assign w_match   = (w_lane == r_launch);
  assign w_tmo     = (r_cnt == L_TMO);
  assign w_cnt_inc = w_tmo ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_cnt     <= '0;
      r_launch  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= '0;
`ifdef CLM_AVG4_EN
      r_pass    <= '0;
      r_acc     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_lane    <= lane_sel;
              r_cnt     <= '0;
              r_timeout <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_SETTLE;
`ifdef CLM_AVG4_EN
              r_pass    <= '0;
              r_acc     <= '0;
`endif
            end
          end
          S_SETTLE: begin
            if (w_match) begin
              r_cnt   <= '0;
              r_state <= S_LAUNCH;
            end else if (w_tmo) begin
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_FINISH;
`ifdef CLM_AVG4_EN
              r_result  <= '1;
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_LAUNCH: begin
            r_launch <= ~r_launch;
            r_cnt    <= '0;
            r_state  <= S_COUNT;
          end
          S_COUNT: begin
            if (w_match) begin
`ifdef CLM_AVG4_EN
              if (r_pass == 2'd3) begin
                r_result <= w_sum[CNT_W+1:2];
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_FINISH;
              end else begin
                r_acc   <= w_sum;
                r_pass  <= r_pass + 2'd1;
                r_cnt   <= '0;
                r_state <= S_SETTLE;
              end
`else
              r_result <= r_cnt;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_FINISH;
`endif
            end else if (w_tmo) begin
              r_result  <= '1;
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_FINISH;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign launch_out = r_launch;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign result     = r_result;

endmodule
